// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, button encodings and driver FSM states shared by the ALU top,
// its command driver and their benches.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    localparam logic [2:0] BTN_A  = 3'b100;
    localparam logic [2:0] BTN_B  = 3'b010;
    localparam logic [2:0] BTN_OP = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_SETTLE,
        S_RESP
    } drv_state_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
    endfunction

endpackage

// File: rtl/alu_hold_timer.sv
// alu_hold_timer: loadable down-counter; done while the count sits at 1.
module alu_hold_timer #(
    parameter int W = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt_d  = load_i ? val_i : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
    assign done_o = cnt_q == W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: replays one (A, B, OP) command as the switch/button load
// sequence of the ALU top, then samples the LEDs and returns the result.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int N_BITS        = 8,
    parameter int N_LEDS        = 8,
    parameter int N_B           = 3,
    parameter int HOLD_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [N_BITS-1:0] i_cmd_a,
    input  logic [N_BITS-1:0] i_cmd_b,
    input  logic [5:0]        i_cmd_op,
    output logic [N_BITS-1:0] o_sw,
    output logic [N_B-1:0]    o_buttons,
    input  logic [N_LEDS-1:0] i_led,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [N_LEDS-1:0] o_result,
    output logic [5:0]        o_res_op,
    output logic              o_err
);

    localparam int CW = $clog2(HOLD_CYCLES > SETTLE_CYCLES ? HOLD_CYCLES : SETTLE_CYCLES) + 1;

    drv_state_t        state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [N_BITS-1:0] a_q, b_q, sel_val;
    logic [5:0]        op_q;
    logic [N_LEDS-1:0] result_q;
    logic              err_q;
    logic [N_B-1:0]    btn_sel;
    logic              accept, tmr_load, tmr_done;
    logic [CW-1:0]     tmr_val;

    assign accept  = state_q == S_IDLE && i_cmd_valid;
    assign sel_val = sel_q == 2'd0 ? a_q : sel_q == 2'd1 ? b_q : {{(N_BITS-6){1'b0}}, op_q};
    assign btn_sel = sel_q == 2'd0 ? N_B'(BTN_A) : sel_q == 2'd1 ? N_B'(BTN_B) : N_B'(BTN_OP);

    alu_hold_timer #(.W(CW)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .done_o (tmr_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        tmr_load = 1'b0;
        tmr_val  = CW'(HOLD_CYCLES);
        case (state_q)
            S_IDLE: if (i_cmd_valid) begin
                state_d = is_legal_op(i_cmd_op) ? S_SETUP : S_RESP;
                sel_d   = '0;
            end
            S_SETUP: begin
                state_d  = S_PULSE;
                tmr_load = 1'b1;
            end
            S_PULSE:  state_d = tmr_done ? S_GAP : S_PULSE;
            S_GAP: if (sel_q == 2'd2) begin
                state_d  = S_SETTLE;
                tmr_load = 1'b1;
                tmr_val  = CW'(SETTLE_CYCLES);
            end else begin
                state_d = S_SETUP;
                sel_d   = sel_q + 2'd1;
            end
            S_SETTLE: state_d = tmr_done ? S_RESP : S_SETTLE;
            S_RESP:   state_d = i_res_ready ? S_IDLE : S_RESP;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decode from registered state, so an async reset drops them at once.
    always_comb begin
        o_cmd_ready = state_q == S_IDLE;
        o_res_valid = state_q == S_RESP;
        o_sw        = state_q inside {S_SETUP, S_PULSE, S_GAP, S_SETTLE} ? sel_val : '0;
        o_buttons   = state_q == S_PULSE ? btn_sel : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            a_q      <= i_cmd_a;
            b_q      <= i_cmd_b;
            op_q     <= i_cmd_op;
            result_q <= '0;
            err_q    <= !is_legal_op(i_cmd_op);
        end else if (state_q == S_SETTLE && tmr_done) begin
            result_q <= i_led;
            err_q    <= 1'b0;
        end
    end

    assign o_result = result_q;
    assign o_res_op = op_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: directed bench with a behavioural ALU top on the switch/button side.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [7:0] i_cmd_a, i_cmd_b;
    logic [5:0] i_cmd_op;
    logic [7:0] o_sw;
    logic [2:0] o_buttons;
    logic [7:0] i_led;
    logic       o_res_valid;
    logic       i_res_ready;
    logic [7:0] o_result;
    logic [5:0] o_res_op;
    logic       o_err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    alu_cmd_driver dut (
        .clock       (clock),
        .reset       (reset),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_a     (i_cmd_a),
        .i_cmd_b     (i_cmd_b),
        .i_cmd_op    (i_cmd_op),
        .o_sw        (o_sw),
        .o_buttons   (o_buttons),
        .i_led       (i_led),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_result    (o_result),
        .o_res_op    (o_res_op),
        .o_err       (o_err)
    );

    // Behavioural ALU top: buttons latch the switches into A, B or OP.
    logic [7:0] ma = '0, mb = '0;
    logic [5:0] mop = '0;

    always @(posedge clock) begin
        if (o_buttons == 3'b100) ma <= o_sw;
        if (o_buttons == 3'b010) mb <= o_sw;
        if (o_buttons == 3'b001) mop <= o_sw[5:0];
    end

    always_comb begin
        i_led = '0;
        case (mop)
            OP_ADD:  i_led = ma + mb;
            OP_SUB:  i_led = ma - mb;
            OP_AND:  i_led = ma & mb;
            OP_OR:   i_led = ma | mb;
            OP_XOR:  i_led = ma ^ mb;
            OP_SRA:  i_led = $signed(ma) >>> mb;
            OP_SRL:  i_led = ma >> mb;
            OP_NOR:  i_led = ~(ma | mb);
            default: i_led = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] prev_sw = '0;

    always @(negedge clock) begin
        if (!reset) begin
            chk("onehot_btn", 32'($onehot0(o_buttons)), 32'd1);
            if (o_buttons != '0) chk("sw_stable", o_sw, prev_sw);
        end
        prev_sw = o_sw;
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        i_cmd_a     = a;
        i_cmd_b     = b;
        i_cmd_op    = op;
        i_cmd_valid = 1'b1;
        @(posedge clock);
        #1 i_cmd_valid = 1'b0;
    endtask

    // Observe each cycle after the accept edge up to the first RESP cycle (index lat).
    task automatic watch(input int lat, input logic [7:0] res, input logic err,
                         input logic [5:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [2:0] exp_btn;
        logic [2:0] first_btn;
        logic [7:0] exp_sw;
        first_btn = 3'b100;
        for (int j = 0; j <= lat; j++) begin
            @(negedge clock);
            exp_btn = (lat > 1 && j < 12 && (j % 4 == 1 || j % 4 == 2)) ? first_btn >> (j / 4) : 3'b000;
            exp_sw  = j / 4 == 0 ? a : j / 4 == 1 ? b : {2'b00, op};
            chk("btn", o_buttons, exp_btn);
            chk("res_valid", o_res_valid, j == lat);
            chk("cmd_ready", o_cmd_ready, 1'b0);
            if (exp_btn != '0) chk("sw_pulse", o_sw, exp_sw);
            if (lat == 0) chk("sw_idle", o_sw, 8'h00);
        end
        chk("result", o_result, res);
        chk("err", o_err, err);
        chk("res_op", o_res_op, op);
        if (i_res_ready) begin
            @(negedge clock);
            chk("ready_after_resp", o_cmd_ready, 1'b1);
            chk("valid_after_resp", o_res_valid, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_a     = '0;
        i_cmd_b     = '0;
        i_cmd_op    = '0;
        i_res_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("rst_ready", o_cmd_ready, 1'b1);
        chk("rst_sw", o_sw, 8'h00);
        chk("rst_btn", o_buttons, 3'b000);
        chk("rst_valid", o_res_valid, 1'b0);
        chk("rst_result", o_result, 8'h00);
        chk("rst_op", o_res_op, 6'h00);
        chk("rst_err", o_err, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        send(8'd10, 8'd3, OP_ADD);
        watch(14, 8'd13, 1'b0, OP_ADD, 8'd10, 8'd3);

        send(8'h80, 8'd2, OP_SRA);
        watch(14, 8'hE0, 1'b0, OP_SRA, 8'h80, 8'd2);
        send(8'h80, 8'd2, OP_SRL);
        watch(14, 8'h20, 1'b0, OP_SRL, 8'h80, 8'd2);

        send(8'd1, 8'd2, 6'b111111);
        watch(0, 8'h00, 1'b1, 6'h3F, 8'd1, 8'd2);

        i_res_ready = 1'b0;
        send(8'h0F, 8'hF0, OP_OR);
        watch(14, 8'hFF, 1'b0, OP_OR, 8'h0F, 8'hF0);
        i_cmd_a     = 8'h33;
        i_cmd_b     = 8'h44;
        i_cmd_op    = OP_AND;
        i_cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("hold_valid", o_res_valid, 1'b1);
            chk("hold_result", o_result, 8'hFF);
            chk("hold_op", o_res_op, OP_OR);
            chk("hold_err", o_err, 1'b0);
            chk("hold_ready", o_cmd_ready, 1'b0);
            chk("hold_btn", o_buttons, 3'b000);
        end
        i_cmd_valid = 1'b0;
        i_res_ready = 1'b1;
        @(negedge clock);
        chk("hold_release_ready", o_cmd_ready, 1'b1);
        @(negedge clock);
        chk("no_stray_accept", o_cmd_ready, 1'b1);
        chk("no_stray_btn", o_buttons, 3'b000);

        send(8'd10, 8'd3, OP_ADD);
        for (int j = 0; j < 6; j++) @(negedge clock);
        chk("pre_reset_btn", o_buttons, 3'b010);
        reset = 1'b1;
        #1;
        chk("async_rst_btn", o_buttons, 3'b000);
        chk("async_rst_sw", o_sw, 8'h00);
        chk("async_rst_ready", o_cmd_ready, 1'b1);
        chk("async_rst_valid", o_res_valid, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", o_cmd_ready, 1'b1);
        send(8'd5, 8'd7, OP_SUB);
        watch(14, 8'hFE, 1'b0, OP_SUB, 8'd5, 8'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
